// File: rtl/demux1x4_router.sv
// 1-to-4 packet demultiplexer with one registered output slot per channel.
// The destination of a multi-beat packet is locked on its first beat.
module demux1x4_router #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [1:0]          in_sel,
    input  logic                in_last,
    output logic [3:0]          out_valid,
    input  logic [3:0]          out_ready,
    output logic [4*DATA_W-1:0] out_data,
    output logic [3:0]          out_last,
    output logic [31:0]         beat_cnt,
    output logic                busy
);

    typedef enum logic {
        IDLE,
        PKT
    } state_t;

    state_t     state;
    logic [1:0] lock_ch;
    logic [1:0] eff_ch;
    logic       accept;

    // A full slot that drains this cycle can take a new beat, so ready
    // looks only at the effective channel's slot and its downstream ready.
    assign eff_ch   = (state == PKT) ? lock_ch : in_sel;
    assign in_ready = !out_valid[eff_ch] || out_ready[eff_ch];
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lock_ch <= 2'd0;
            busy    <= 1'b0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (!in_last) begin
                        state   <= PKT;
                        lock_ch <= in_sel;
                        busy    <= 1'b1;
                    end
                end
                PKT: begin
                    if (in_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Loading wins over draining; slots not addressed drain on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 4'd0;
            out_last  <= 4'd0;
            out_data  <= '0;
            beat_cnt  <= 32'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (accept && (eff_ch == 2'(k))) begin
                    out_valid[k]                <= 1'b1;
                    out_last[k]                 <= in_last;
                    out_data[k*DATA_W +: DATA_W] <= in_data;
                    beat_cnt[k*8 +: 8]          <= beat_cnt[k*8 +: 8] + 8'd1;
                end else if (out_valid[k] && out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux1x4_router.sv
// Randomized and directed bench for demux1x4_router; per-channel expected
// beats wait in queues until the monitor sees them leave the DUT.
module tb_demux1x4_router;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [1:0]        in_sel = 2'd0;
    logic              in_last = 1'b0;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready = 4'hF;
    logic [4*DATA_W-1:0] out_data;
    logic [3:0]        out_last;
    logic [31:0]       beat_cnt;
    logic              busy;

    int total = 0;
    int bad = 0;

    // Reference model: slot contents as queues, open packet destination, counts.
    logic [DATA_W:0] exp_q [4][$];
    int open_dest = -1;
    int cnt_model [4] = '{0, 0, 0, 0};
    logic pre_ready;

    demux1x4_router #(.DATA_W(DATA_W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_sel(in_sel),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .beat_cnt(beat_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, note in_ready before the edge, return just after it.
    task automatic apply_stimulus(input logic v, input logic [1:0] s, input logic [7:0] d,
                                  input logic l, input logic [3:0] r, input logic rs);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        rst       = rs;
        #1;
        pre_ready = in_ready;
        @(posedge clk);
        #1;
    endtask

    // Model update, late in the low phase so the monitor has already sampled.
    initial begin
        int ch;
        logic exp_ready;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #2;
            ch = (open_dest >= 0) ? open_dest : int'(in_sel);
            exp_ready = (exp_q[ch].size() == 0) || out_ready[ch];
            check_output("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            if (rst) begin
                for (int k = 0; k < 4; k++) begin
                    exp_q[k].delete();
                    cnt_model[k] = 0;
                end
                open_dest = -1;
            end else if (in_valid && exp_ready) begin
                exp_q[ch].push_back({in_last, in_data});
                cnt_model[ch] = (cnt_model[ch] + 1) % 256;
                open_dest = in_last ? -1 : ch;
            end
        end
    end

    // Monitor: compares visible outputs and pops beats as they drain.
    initial begin
        logic [DATA_W:0] item;
        logic [31:0] exp_cnt;
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                check_output($sformatf("out_valid[%0d]", k), {31'd0, out_valid[k]},
                             {31'd0, exp_q[k].size() != 0});
                if (exp_q[k].size() != 0 && out_ready[k]) begin
                    item = exp_q[k].pop_front();
                    check_output($sformatf("out_data[%0d]", k),
                                 {24'd0, out_data[k*DATA_W +: DATA_W]}, {24'd0, item[DATA_W-1:0]});
                    check_output($sformatf("out_last[%0d]", k), {31'd0, out_last[k]},
                                 {31'd0, item[DATA_W]});
                end
            end
            check_output("busy", {31'd0, busy}, {31'd0, open_dest >= 0});
            for (int k = 0; k < 4; k++) exp_cnt[k*8 +: 8] = 8'(cnt_model[k]);
            check_output("beat_cnt", beat_cnt, exp_cnt);
        end
    end

    initial begin
        @(posedge clk);
        #1;
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1);
        check_output("reset out_valid", {28'd0, out_valid}, 32'd0);
        check_output("reset out_data", out_data, 32'd0);
        check_output("reset out_last", {28'd0, out_last}, 32'd0);
        check_output("reset beat_cnt", beat_cnt, 32'd0);
        check_output("reset busy", {31'd0, busy}, 32'd0);
        check_output("reset in_ready", {31'd0, in_ready}, 32'd1);

        // Single-beat packet to channel 2
        apply_stimulus(1'b1, 2'd2, 8'hA5, 1'b1, 4'hF, 1'b0);
        check_output("single out_valid", {28'd0, out_valid}, 32'h4);
        check_output("single data", {24'd0, out_data[23:16]}, 32'hA5);
        check_output("single last", {31'd0, out_last[2]}, 32'd1);
        check_output("single busy", {31'd0, busy}, 32'd0);
        check_output("single cnt", {24'd0, beat_cnt[23:16]}, 32'd1);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b0);

        // Packet lock: destination fixed by first beat
        apply_stimulus(1'b1, 2'd1, 8'h11, 1'b0, 4'hF, 1'b0);
        check_output("lock busy1", {31'd0, busy}, 32'd1);
        apply_stimulus(1'b1, 2'd3, 8'h22, 1'b0, 4'hF, 1'b0);
        check_output("lock ch beat2", {28'd0, out_valid}, 32'h2);
        apply_stimulus(1'b1, 2'd0, 8'h33, 1'b1, 4'hF, 1'b0);
        check_output("lock ch beat3", {28'd0, out_valid}, 32'h2);
        check_output("lock data3", {24'd0, out_data[15:8]}, 32'h33);
        check_output("lock busy3", {31'd0, busy}, 32'd0);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b0);

        // Backpressure on channel 0
        apply_stimulus(1'b1, 2'd0, 8'h44, 1'b1, 4'hE, 1'b0);
        apply_stimulus(1'b1, 2'd0, 8'h55, 1'b1, 4'hE, 1'b0);
        check_output("bp stalled ready", {31'd0, pre_ready}, 32'd0);
        check_output("bp held data", {24'd0, out_data[7:0]}, 32'h44);
        apply_stimulus(1'b1, 2'd0, 8'h55, 1'b1, 4'hF, 1'b0);
        check_output("bp drain ready", {31'd0, pre_ready}, 32'd1);
        check_output("bp second data", {24'd0, out_data[7:0]}, 32'h55);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b0);

        // Independence: channel 0 stalled, channel 3 still flows
        apply_stimulus(1'b1, 2'd0, 8'h66, 1'b1, 4'hE, 1'b0);
        apply_stimulus(1'b1, 2'd3, 8'h77, 1'b1, 4'hE, 1'b0);
        check_output("indep ready", {31'd0, pre_ready}, 32'd1);
        check_output("indep out_valid", {28'd0, out_valid}, 32'h9);
        check_output("indep data3", {24'd0, out_data[31:24]}, 32'h77);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b0);

        // Counter wrap on channel 1
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1);
        for (int i = 0; i < 256; i++)
            apply_stimulus(1'b1, 2'd1, 8'(i), 1'b1, 4'hF, 1'b0);
        check_output("wrap 256", {24'd0, beat_cnt[15:8]}, 32'd0);
        apply_stimulus(1'b1, 2'd1, 8'hFE, 1'b1, 4'hF, 1'b0);
        check_output("wrap 257", {24'd0, beat_cnt[15:8]}, 32'd1);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b0);

        // Reset in the middle of a packet
        apply_stimulus(1'b1, 2'd2, 8'h88, 1'b0, 4'hF, 1'b0);
        check_output("mid busy", {31'd0, busy}, 32'd1);
        apply_stimulus(1'b1, 2'd2, 8'h99, 1'b1, 4'hF, 1'b1);
        check_output("mid rst out_valid", {28'd0, out_valid}, 32'd0);
        check_output("mid rst out_data", out_data, 32'd0);
        check_output("mid rst beat_cnt", beat_cnt, 32'd0);
        check_output("mid rst busy", {31'd0, busy}, 32'd0);
        apply_stimulus(1'b1, 2'd0, 8'hBB, 1'b1, 4'hF, 1'b0);
        check_output("post rst out_valid", {28'd0, out_valid}, 32'h1);
        check_output("post rst data", {24'd0, out_data[7:0]}, 32'hBB);

        // Random traffic with occasional resets and backpressure
        for (int i = 0; i < 1500; i++) begin
            apply_stimulus(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                           8'($urandom), 1'($urandom_range(0, 3) == 0),
                           4'($urandom), 1'($urandom_range(0, 63) == 0));
        end
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b0);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b0);
        @(negedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
